serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_sub_pkg.sv | 19 +
 rtl/full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 138 +++++++++++++
 tb/tb_serial_subtractor.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM states,
// default operand width and the signed-overflow helper.
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Two's-complement overflow of a-b: operands differ in sign and the
  // result sign differs from the minuend sign.
  function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
    return (a_msb ^ b_msb) & (a_msb ^ d_msb);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a-b LSB-first, one bit per clock,
// reporting the difference, final borrow and signed overflow.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  // Only the upper WIDTH-1 result bits need storing; the last bit is
  // produced combinationally on the completing edge.
  logic [WIDTH-2:0] r_res;
  logic             r_borrow;
  logic             r_amsb;
  logic             r_bmsb;
  logic [CNT_W-1:0] r_cnt;

  logic             w_d;
  logic             w_bout;
  logic [WIDTH-1:0] w_res_next;
  logic             w_last;

  full_subtractor u_fs (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .bin  (r_borrow),
    .d    (w_d),
    .bout (w_bout)
  );

  assign w_res_next = {w_d, r_res};
  assign w_last     = (r_cnt == LAST_CNT);

  // Next-state decode for the IDLE -> SHIFT -> DONE sequence.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next_state = SHIFT;
        end else begin
          w_next_state = IDLE;
        end
      end
      SHIFT: begin
        if (w_last) begin
          w_next_state = DONE;
        end else begin
          w_next_state = SHIFT;
        end
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // State register with busy/done registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      busy    <= (w_next_state == SHIFT);
      done    <= (w_next_state == DONE);
    end
  end

  // Operand capture, per-bit shifting and result loading at completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_borrow <= 1'b0;
      r_amsb   <= 1'b0;
      r_bmsb   <= 1'b0;
      r_cnt    <= '0;
      diff     <= '0;
      bout     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a      <= a;
            r_b      <= b;
            r_borrow <= 1'b0;
            r_amsb   <= a[WIDTH-1];
            r_bmsb   <= b[WIDTH-1];
            r_cnt    <= '0;
          end else begin
            r_cnt    <= r_cnt;
          end
        end
        SHIFT: begin
          r_a      <= {1'b0, r_a[WIDTH-1:1]};
          r_b      <= {1'b0, r_b[WIDTH-1:1]};
          r_res    <= w_res_next[WIDTH-1:1];
          r_borrow <= w_bout;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (w_last) begin
            diff <= w_res_next;
            bout <= w_bout;
            ovf  <= sub_ovf(r_amsb, r_bmsb, w_d);
          end else begin
            diff <= diff;
          end
        end
        DONE: begin
          r_cnt <= r_cnt;
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): a cycle-level
// arithmetic reference model compared every cycle, plus literal checks.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy, done, bout, ovf;
  logic [W-1:0] diff;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf)
  );

  // Reference arithmetic: returns {ovf, bout, diff}.
  function automatic logic [W+1:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] d;
    int sx, sy, sr;
    logic o;
    d  = x - y;
    sx = $signed(x);
    sy = $signed(y);
    sr = sx - sy;
    o  = (sr > (2 ** (W - 1)) - 1) || (sr < -(2 ** (W - 1)));
    return {o, (x < y), d};
  endfunction

  // Behavioural model: m_phase 0 = idle, 1..W = busy, W+1 = done.
  int           m_phase = 0;
  logic [W-1:0] m_diff = '0, p_diff = '0;
  logic         m_bout = 1'b0, m_ovf = 1'b0, p_bout = 1'b0, p_ovf = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_diff  <= '0;
      m_bout  <= 1'b0;
      m_ovf   <= 1'b0;
    end else if (m_phase == 0) begin
      if (start === 1'b1) begin
        {p_ovf, p_bout, p_diff} <= ref_sub(a, b);
        m_phase <= 1;
      end
    end else if (m_phase < W) begin
      m_phase <= m_phase + 1;
    end else if (m_phase == W) begin
      m_phase <= W + 1;
      m_diff  <= p_diff;
      m_bout  <= p_bout;
      m_ovf   <= p_ovf;
    end else begin
      m_phase <= 0;
    end
  end

  function automatic logic [31:0] model_vec();
    logic mb, md;
    mb = (m_phase >= 1) && (m_phase <= W);
    md = (m_phase == W + 1);
    return {20'd0, mb, md, m_bout, m_ovf, m_diff};
  endfunction

  function automatic logic [31:0] dut_vec();
    return {20'd0, busy, done, bout, ovf, diff};
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: actual %h required %h ({busy,done,bout,ovf,diff})", name, $time, act, exp);
    end
  endtask

  // Wait for a done pulse, returning the number of negedges it took.
  task automatic wait_done(output int cycles);
    cycles = 0;
    for (int i = 1; i <= 2 * W + 4; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        cycles = i;
        break;
      end
    end
    if (cycles == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_done @%0t: no done pulse within %0d cycles", $time, 2 * W + 4);
    end
  endtask

  task automatic lit(input string name, input logic [W-1:0] ed, input logic eb, input logic eo);
    cmp(name, dut_vec(), {20'd0, 1'b0, 1'b1, eb, eo, ed});
    cmp({name, "_model"}, model_vec(), {20'd0, 1'b0, 1'b1, eb, eo, ed});
  endtask

  task automatic pulse_start(input logic [W-1:0] av, input logic [W-1:0] bv);
    @(posedge clk);
    #2;
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] ed, input logic eb, input logic eo);
    int cyc;
    pulse_start(av, bv);
    wait_done(cyc);
    cmp({name, "_latency"}, cyc, W + 1);
    lit(name, ed, eb, eo);
  endtask

  initial begin
    int cyc;
    int nd;
    #1 rst_n = 1'b0;
    fork
      begin : compare_proc
        forever begin
          @(negedge clk);
          cmp("cycle", dut_vec(), model_vec());
        end
      end
      begin : stimulus
        repeat (2) @(negedge clk);
        cmp("reset_state", dut_vec(), 32'd0);
        #2 rst_n = 1'b1;

        run_op("sub_05_03", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
        run_op("sub_03_05", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
        run_op("sub_00_00", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        run_op("sub_80_01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        run_op("sub_7F_FF", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);

        // start and operand changes during SHIFT and DONE are ignored
        pulse_start(8'h05, 8'h03);
        repeat (3) @(posedge clk);
        #2;
        start = 1'b1; a = 8'hAA; b = 8'h11;
        @(posedge clk);
        #2;
        start = 1'b0; a = 8'h00; b = 8'h00;
        wait_done(cyc);
        lit("ignore_shift", 8'h02, 1'b0, 1'b0);
        #2;
        start = 1'b1; a = 8'h33; b = 8'h44;
        @(posedge clk);
        #2;
        start = 1'b0;
        repeat (W + 4) @(negedge clk);
        cmp("hold_after_ignored", dut_vec(), {20'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h02});

        // reset in the middle of SHIFT aborts; fresh start after release
        pulse_start(8'h9C, 8'h37);
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 cmp("reset_abort", dut_vec(), 32'd0);
        repeat (2) @(negedge clk);
        a = 8'h9C; b = 8'h37; start = 1'b1;
        #2 rst_n = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
        wait_done(cyc);
        cmp("post_reset_latency", cyc, W + 1);
        lit("post_reset_9C_37", 8'h65, 1'b0, 1'b1);

        // start held high for 40 cycles with operands changing every cycle
        @(posedge clk);
        #2 start = 1'b1;
        nd = 0;
        for (int i = 0; i < 40; i++) begin
          a = W'($urandom);
          b = W'($urandom);
          @(negedge clk);
          if (done === 1'b1) nd++;
          @(posedge clk);
          #2;
        end
        start = 1'b0;
        cmp("held_start_dones", nd, 4);
        repeat (W + 4) @(negedge clk);

        // random single operations with random gaps
        for (int i = 0; i < 20; i++) begin
          pulse_start(W'($urandom), W'($urandom));
          wait_done(cyc);
          repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        repeat (3) @(negedge clk);
      end
    join_any
    disable fork;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
